// File: rtl/regfl_alu_seq.sv
// Sequencer that reads two registers, adds or subtracts them, and writes the result back.
// Optional subtract support is enabled by defining REGFL_SEQ_SUB_EN.
module regfl_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             op,
    input  logic [1:0]       src_a,
    input  logic [1:0]       src_b,
    input  logic [1:0]       dst,
    output logic [1:0]       rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic [1:0]       wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             wr_e,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        EXEC,
        WB,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [1:0]       sa_q;
    logic [1:0]       sb_q;
    logic [1:0]       dst_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   sum;

`ifdef REGFL_SEQ_SUB_EN
    logic op_q;

    // The extra MSB of the difference is the borrow (set when A < B)
    always_comb begin
        if (op_q) begin
            sum = {1'b0, a_q} - {1'b0, b_q};
        end else begin
            sum = {1'b0, a_q} + {1'b0, b_q};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            op_q <= op;
        end
    end
`else
    logic op_unused;

    assign op_unused = op;
    assign sum       = {1'b0, a_q} + {1'b0, b_q};
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            sa_q    <= 2'b00;
            sb_q    <= 2'b00;
            dst_q   <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            result  <= '0;
            carry   <= 1'b0;
        end else begin
            state_q <= state_n;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q  <= src_a;
                        sb_q  <= src_b;
                        dst_q <= dst;
                    end
                end
                RD_A:    a_q <= rd_data;
                RD_B:    b_q <= rd_data;
                EXEC:    {carry, result} <= sum;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state_q;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        rd_addr = 2'b00;
        wr_e    = 1'b0;
        wr_addr = 2'b00;
        wr_data = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = RD_A;
                end
            end
            RD_A: begin
                rd_addr = sa_q;
                state_n = RD_B;
            end
            RD_B: begin
                rd_addr = sb_q;
                state_n = EXEC;
            end
            EXEC: begin
                state_n = WB;
            end
            WB: begin
                wr_e    = 1'b1;
                wr_addr = dst_q;
                wr_data = result;
                state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfl_alu_seq.sv
// Bench for regfl_alu_seq: table vectors, randomized operations, reset abort.
// Holds the 4x8 register file that the sequencer reads and writes.
module tb_regfl_alu_seq;

    logic       clk;
    logic       rst_b;
    logic       start;
    logic       op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] dst;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_e;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;

    logic [7:0] rf [4];
    logic       ld;
    logic [7:0] ld_v [4];
    int         wr_cnt;
    int         checks;
    int         errors;

    regfl_alu_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .dst     (dst),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_e    (wr_e),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_data = rf[rd_addr];

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 4; i++) rf[i] <= ld_v[i];
        end else if (wr_e) begin
            rf[wr_addr] <= wr_data;
        end
        if (wr_e) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] r0, r1, r2, r3);
        @(negedge clk);
        ld_v[0] = r0;
        ld_v[1] = r1;
        ld_v[2] = r2;
        ld_v[3] = r3;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    // Reference: plain integer arithmetic on the register contents
    task automatic model(input logic o, input logic [1:0] sa, sb,
                         output logic [7:0] er, output logic ec);
        int a;
        int b;
        int s;
        a = int'(rf[sa]);
        b = int'(rf[sb]);
        s = a + b;
`ifdef REGFL_SEQ_SUB_EN
        if (o) s = a - b;
`else
        if (o) s = a + b;
`endif
        er = 8'((s + 512) % 256);
        ec = (s > 255) || (s < 0);
    endtask

    task automatic run_op(input logic o, input logic [1:0] sa, sb, d,
                          input logic [7:0] er, input logic ec);
        int w0;
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = sa;
        src_b = sb;
        dst   = d;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("busy", busy, 1'b1);
            chk("wr_e", wr_e, i == 4);
            chk("done", done, i == 5);
            if (i == 1) chk("rd_a", rd_addr, sa);
            else if (i == 2) chk("rd_b", rd_addr, sb);
            else chk("rd_idle", rd_addr, 2'b00);
            if (i == 4) begin
                chk("wr_addr", wr_addr, d);
                chk("wr_data", wr_data, er);
            end
            if (i < 5) begin
                start = (i == 2) ? 1'b1 : 1'($urandom);
                op    = 1'($urandom);
                src_a = 2'($urandom);
                src_b = 2'($urandom);
                dst   = 2'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("busy_end", busy, 1'b0);
        chk("done_end", done, 1'b0);
        chk("rf_dst", rf[d], er);
        chk("result", result, er);
        chk("carry", carry, ec);
        chk("one_write", wr_cnt - w0, 1);
        @(negedge clk);
        chk("no_requeue", busy, 1'b0);
    endtask

    typedef struct {
        logic       o;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] d;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] er;
        logic       ec;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [7:0] er;
        logic       ec;
        logic [7:0] old;
        int         w0;

        tbl[0] = '{1'b0, 2'd0, 2'd1, 2'd2, 8'h12, 8'h34, 8'h46, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 2'd1, 2'd3, 8'hF0, 8'h20, 8'h10, 1'b1};
`ifdef REGFL_SEQ_SUB_EN
        tbl[2] = '{1'b1, 2'd0, 2'd1, 2'd0, 8'h05, 8'h07, 8'hFE, 1'b1};
`else
        tbl[2] = '{1'b1, 2'd0, 2'd1, 2'd0, 8'h05, 8'h07, 8'h0C, 1'b0};
`endif
        tbl[3] = '{1'b0, 2'd1, 2'd1, 2'd1, 8'h00, 8'h40, 8'h80, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 2'd0, 2'd0, 8'hFF, 8'h00, 8'hFE, 1'b1};

        checks = 0;
        errors = 0;
        wr_cnt = 0;
        ld     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_v[i] = 8'h00;
            rf[i]   = 8'h00;
        end
        rst_b = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        src_a = 2'd0;
        src_b = 2'd0;
        dst   = 2'd0;
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wr_e", wr_e, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_carry", carry, 1'b0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        for (int t = 0; t < 5; t++) begin
            load(tbl[t].r0, tbl[t].r1, 8'hAA, 8'h55);
            run_op(tbl[t].o, tbl[t].sa, tbl[t].sb, tbl[t].d, tbl[t].er, tbl[t].ec);
        end

        for (int t = 0; t < 40; t++) begin
            logic       o;
            logic [1:0] sa;
            logic [1:0] sb;
            logic [1:0] d;
            load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            o  = 1'($urandom);
            sa = 2'($urandom);
            sb = 2'($urandom);
            d  = 2'($urandom);
            model(o, sa, sb, er, ec);
            run_op(o, sa, sb, d, er, ec);
        end

        // Reset while the operation is in EXEC must abort the write
        load(8'h11, 8'h22, 8'h33, 8'h44);
        old = rf[3];
        w0  = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        src_a = 2'd1;
        src_b = 2'd2;
        dst   = 2'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_wr_e", wr_e, 1'b0);
        chk("abort_rd_addr", rd_addr, 2'b00);
        chk("abort_wr_addr", wr_addr, 2'b00);
        chk("abort_wr_data", wr_data, 8'h00);
        chk("abort_result", result, 8'h00);
        chk("abort_carry", carry, 1'b0);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_idle", busy, 1'b0);
        end
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_dst", rf[3], old);

        load(8'h01, 8'h02, 8'h03, 8'h04);
        model(1'b0, 2'd2, 2'd3, er, ec);
        run_op(1'b0, 2'd2, 2'd3, 2'd0, er, ec);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfl_alu_seq.md
REGFL_ALU_SEQ -- requirements
Module: regfl_alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the register data width, matching the 4x8 register file.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_b, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin one operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 1 bit, operation select: 0 = add, 1 = subtract (subtract only with REGFL_SEQ_SUB_EN).
REQ-006 The block SHALL have ports src_a, src_b and dst, each input, 2 bits, the operand and destination register addresses.
REQ-007 The block SHALL have port rd_addr, output, 2 bits, the register-file read address.
REQ-008 The block SHALL have port rd_data, input, WIDTH bits, the register-file read data, combinational from rd_addr in the same cycle.
REQ-009 The block SHALL have ports wr_addr (output, 2 bits), wr_data (output, WIDTH bits) and wr_e (output, 1 bit), the register-file write port; the write commits on the clk edge while wr_e=1.
REQ-010 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-012 The block SHALL have port result, output, WIDTH bits, the last computed value, held until the next operation.
REQ-013 The block SHALL have port carry, output, 1 bit, the carry-out (add) or borrow (subtract) of the last operation, held until the next operation.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, RD_A, RD_B, EXEC, WB, DONE; all outputs SHALL be decoded from registered state and data only.
REQ-015 In IDLE with start=1 at an edge, the block SHALL latch op, src_a, src_b and dst, then go to RD_A; with start=0 it SHALL stay in IDLE.
REQ-016 RD_A SHALL drive rd_addr=src_a (latched), capture rd_data into operand A at the closing edge, then go to RD_B.
REQ-017 RD_B SHALL drive rd_addr=src_b (latched), capture rd_data into operand B, then go to EXEC.
REQ-018 EXEC SHALL compute {carry,result} = A+B as a WIDTH+1-bit sum, or A-B with carry = borrow (A<B) for a subtract, register it, then go to WB.
REQ-019 WB SHALL assert wr_e=1, wr_addr=dst and wr_data=result for exactly one cycle, then go to DONE.
REQ-020 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-021 Outside WB, wr_e SHALL be 0; outside RD_A and RD_B, rd_addr SHALL be 2'b00.
REQ-022 Latency: with start sampled at edge k, wr_e SHALL be high in cycle k+4 and done high in cycle k+5; the next start is accepted at the edge closing the DONE cycle at the earliest.
REQ-023 A start asserted while busy=1 SHALL be ignored, not queued; input changes while busy SHALL not affect the operation in flight.
REQ-024 src_a=src_b SHALL be legal (the same register is read twice); dst equal to either source SHALL be legal, and both reads SHALL complete before the write.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH, with the overflow bit reported only on carry.

Reset
REQ-026 With rst_b=0, asynchronously and regardless of clk: state=IDLE, busy=0, done=0, wr_e=0, rd_addr=0, wr_addr=0, wr_data=0, result=0, carry=0, and operand registers 0.
REQ-027 A reset during any state SHALL abort the operation with no write issued afterwards; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-028 Macro REGFL_SEQ_SUB_EN defined: op=1 SHALL select subtract as in REQ-018.
REQ-029 Macro REGFL_SEQ_SUB_EN undefined: op SHALL be ignored, every operation SHALL be an add, and no subtractor SHALL be synthesised.

Verification
REQ-030 Regfile R0=8'h12, R1=8'h34; start with op=0, src_a=0, src_b=1, dst=2 -> R2=8'h46, carry=0, done high 5 cycles after start.
REQ-031 R0=8'hF0, R1=8'h20; add into dst=3 -> R3=8'h10, carry=1.
REQ-032 With REGFL_SEQ_SUB_EN: R0=8'h05, R1=8'h07; op=1, dst=0 -> R0=8'hFE, carry=1; without the macro, the same stimulus -> R0=8'h0C, carry=0.
REQ-033 src_a=src_b=dst=1 with R1=8'h40 -> R1=8'h80 after one write; wr_e high for exactly one cycle.
REQ-034 start pulsed again during RD_B -> ignored; only one done pulse; busy stays high through DONE.
REQ-035 rst_b driven low during EXEC -> wr_e never asserts, destination unchanged, all outputs 0 immediately.
